// File: rtl/leb128_fetch_pkg.sv
// Shared definitions for the LEB128 immediate fetch stage: FSM states,
// error codes returned to the core, and per-width byte limits.
package leb128_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WIN_WAIT  = 3'd1,
        WIN_DEC   = 3'd2,
        BYTE_WAIT = 3'd3,
        BYTE_DEC  = 3'd4
    } leb_state_t;

    typedef enum logic [1:0] {
        LEB_OK       = 2'd0,
        LEB_MEMERR   = 2'd1,
        LEB_TOOLONG  = 2'd2,
        LEB_OVERFLOW = 2'd3
    } leb_err_t;

    localparam int LIMIT32 = 5;
    localparam int LIMIT64 = 10;

    // Maximum number of encoded bytes allowed for the requested width.
    function automatic logic [3:0] byte_limit(input logic wide);
        return wide ? 4'(LIMIT64) : 4'(LIMIT32);
    endfunction

endpackage

// File: rtl/leb128_fetch_if.sv
// Request/response handshake to the core plus the genrom read port,
// bundled so the fetch stage sees one bus.
interface leb128_fetch_if #(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
);
    logic                         req;
    logic [MEM_DEPTH:0]           req_pc;
    logic                         req_signed;
    logic                         req_wide;
    logic                         busy;
    logic                         done;
    logic [63:0]                  value;
    logic [MEM_DEPTH:0]           next_pc;
    logic [1:0]                   err;
    logic [MEM_DEPTH:0]           mem_addr;
    logic [MEM_EXTRA-1:0]         mem_extra;
    logic [(2**MEM_EXTRA)*8-1:0]  mem_data;
    logic                         mem_error;

    modport master (
        output req, req_pc, req_signed, req_wide, mem_data, mem_error,
        input  busy, done, value, next_pc, err, mem_addr, mem_extra
    );

    modport slave (
        input  req, req_pc, req_signed, req_wide, mem_data, mem_error,
        output busy, done, value, next_pc, err, mem_addr, mem_extra
    );
endinterface

// File: rtl/leb128_fetch_acc.sv
// Per-byte LEB128 accumulator: shifts in 7 payload bits per step and
// reports termination, length/overflow violations and the extended result.
module leb128_fetch_acc
    import leb128_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        step,
    input  logic [7:0]  byte_in,
    input  logic        is_signed,
    input  logic        is_wide,
    output logic [3:0]  count,
    output logic        term,
    output logic        too_long,
    output logic        overflow,
    output logic [63:0] result
);

    logic [63:0] acc_q;
    logic [3:0]  count_q;
    logic [3:0]  last_idx;
    logic [6:0]  shamt;
    logic [6:0]  bits_done;
    logic [63:0] acc_new;
    logic [63:0] fill_mask;
    logic [63:0] extended;
    logic [6:0]  payload;

    // All flags and the result describe the state after byte_in is absorbed.
    always_comb begin
        payload   = byte_in[6:0];
        last_idx  = byte_limit(is_wide) - 4'd1;
        shamt     = 7'(count_q) * 7'd7;
        bits_done = shamt + 7'd7;
        acc_new   = acc_q | ({57'd0, payload} << shamt);
        term      = ~byte_in[7];
        too_long  = byte_in[7] && (count_q == last_idx);

        overflow = 1'b0;
        if (term && (count_q == last_idx)) begin
            case ({is_wide, is_signed})
                2'b00:   overflow = (payload[6:4] != 3'd0);
                2'b01:   overflow = (payload[6:3] != {4{payload[3]}});
                2'b10:   overflow = (payload[6:1] != 6'd0);
                default: overflow = (payload[6:0] != {7{payload[0]}});
            endcase
        end

        fill_mask = '0;
        if (is_signed && byte_in[6] && (bits_done < 7'd64)) begin
            fill_mask = ~64'd0 << bits_done;
        end
        extended = acc_new | fill_mask;

        if (is_wide) begin
            result = extended;
        end else begin
            result = {(is_signed ? {32{extended[31]}} : 32'd0), extended[31:0]};
        end
    end

    // Accumulator and shift counter; cleared at the start of every decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            acc_q   <= '0;
            count_q <= '0;
        end else if (step) begin
            acc_q   <= acc_new;
            count_q <= count_q + 4'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/leb128_fetch.sv
// LEB128 immediate fetch: tries one wide ROM window read, falling back to
// byte-at-a-time reads when the window runs past the end of the ROM.
module leb128_fetch
    import leb128_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    leb128_fetch_if.slave   bus
);

    localparam int AW = MEM_DEPTH + 1;
    localparam int DW = (2**MEM_EXTRA) * 8;

    leb_state_t          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [63:0]         value_q, value_d;
    logic [AW-1:0]       next_pc_q, next_pc_d;
    leb_err_t            err_q, err_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic                signed_q, signed_d;
    logic                wide_q, wide_d;
    logic [DW-1:0]       win_q, win_d;

    logic        acc_clear;
    logic        acc_step;
    logic [7:0]  cur_byte;
    logic [3:0]  acc_count;
    logic        acc_term;
    logic        acc_too_long;
    logic        acc_overflow;
    logic [63:0] acc_result;

    leb128_fetch_acc u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (acc_clear),
        .step      (acc_step),
        .byte_in   (cur_byte),
        .is_signed (signed_q),
        .is_wide   (wide_q),
        .count     (acc_count),
        .term      (acc_term),
        .too_long  (acc_too_long),
        .overflow  (acc_overflow),
        .result    (acc_result)
    );

    // Next-state and datapath updates; the done-producing cases are shared
    // between window and byte mode through the accumulator flags.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        value_d     = value_q;
        next_pc_d   = next_pc_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_extra_d = mem_extra_q;
        pc_d        = pc_q;
        signed_d    = signed_q;
        wide_d      = wide_q;
        win_d       = win_q;
        acc_clear   = 1'b0;
        acc_step    = 1'b0;
        cur_byte    = 8'd0;

        case (state_q)
            IDLE: begin
                // The cycle carrying done still looks idle but must not accept.
                if (bus.req && !done_q) begin
                    mem_addr_d  = bus.req_pc;
                    mem_extra_d = bus.req_wide ? MEM_EXTRA'(9) : MEM_EXTRA'(4);
                    pc_d        = bus.req_pc;
                    signed_d    = bus.req_signed;
                    wide_d      = bus.req_wide;
                    busy_d      = 1'b1;
                    acc_clear   = 1'b1;
                    state_d     = WIN_WAIT;
                end
            end

            WIN_WAIT: state_d = WIN_DEC;

            WIN_DEC: begin
                if ((acc_count == 4'd0) && bus.mem_error) begin
                    mem_extra_d = '0;
                    mem_addr_d  = pc_q;
                    state_d     = BYTE_WAIT;
                end else begin
                    if (acc_count == 4'd0) begin
                        win_d    = bus.mem_data;
                        cur_byte = bus.mem_data[7:0];
                    end else begin
                        cur_byte = win_q[{acc_count, 3'b000} +: 8];
                    end
                    acc_step = 1'b1;
                end
            end

            BYTE_WAIT: state_d = BYTE_DEC;

            BYTE_DEC: begin
                if (bus.mem_error) begin
                    err_d     = LEB_MEMERR;
                    next_pc_d = mem_addr_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cur_byte   = bus.mem_data[7:0];
                    acc_step   = 1'b1;
                    mem_addr_d = mem_addr_q + AW'(1);
                    state_d    = BYTE_WAIT;
                end
            end

            default: state_d = IDLE;
        endcase

        if (acc_step && (acc_too_long || acc_term)) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
            value_d   = acc_result;
            if (acc_too_long) begin
                err_d     = LEB_TOOLONG;
                next_pc_d = pc_q + AW'(byte_limit(wide_q));
            end else begin
                err_d     = acc_overflow ? LEB_OVERFLOW : LEB_OK;
                next_pc_d = pc_q + AW'(acc_count) + AW'(1);
            end
        end
    end

    // State and datapath registers; reset aborts any decode in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_q     <= '0;
            next_pc_q   <= '0;
            err_q       <= LEB_OK;
            mem_addr_q  <= '0;
            mem_extra_q <= '0;
            pc_q        <= '0;
            signed_q    <= 1'b0;
            wide_q      <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            value_q     <= value_d;
            next_pc_q   <= next_pc_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_extra_q <= mem_extra_d;
            pc_q        <= pc_d;
            signed_q    <= signed_d;
            wide_q      <= wide_d;
            win_q       <= win_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.value     = value_q;
    assign bus.next_pc   = next_pc_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_extra = mem_extra_q;

endmodule

// File: doc/leb128_fetch.md
Name: leb128_fetch

Overview:
Immediate-operand fetch stage that sits between genrom and the cpu core's execute logic. On request it reads a LEB128-encoded immediate at a given pc from the ROM port and decodes it as u32, s32, u64 or s64. It returns the decoded value, the pc just past the immediate, and an error code that the core maps onto its trap output. The ROM port signals connect one-to-one to genrom (addr/extra/data/error).

Parameters:
MEM_DEPTH, 6, address MSB index; addresses are MEM_DEPTH+1 bits wide.
MEM_EXTRA, 4, genrom extra-byte field width; data bus is 2**MEM_EXTRA*8 bits; must be >=4 so one read can cover 10 bytes.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
req  in  1  start decode; sampled only when busy=0
req_pc  in  MEM_DEPTH+1  byte address of first LEB byte
req_signed  in  1  1 = signed LEB (sign-extend)
req_wide  in  1  1 = 64-bit, 0 = 32-bit
busy  out  1  decode in progress
done  out  1  one-cycle pulse; value/next_pc/err valid while high and held until next accept
value  out  64  decoded immediate
next_pc  out  MEM_DEPTH+1  req_pc + bytes consumed, modulo 2**(MEM_DEPTH+1)
err  out  2  0 ok, 1 memory error, 2 too long, 3 overflow
mem_addr  out  MEM_DEPTH+1  ROM address
mem_extra  out  MEM_EXTRA  extra bytes requested
mem_data  in  2**MEM_EXTRA*8  ROM data, byte at mem_addr in bits [7:0], registered one cycle after addr
mem_error  in  1  ROM out-of-bounds, aligned with mem_data

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy, done, value, next_pc, err, mem_addr and mem_extra all 0. Asserting reset mid-decode aborts the decode and produces no done pulse.
- State IDLE: req=1 at edge E0 registers mem_addr=req_pc and mem_extra=(req_wide?9:4). Next state WIN_WAIT; busy=1.
- State WIN_WAIT: genrom samples the address at E1. Next state WIN_DEC.
- State WIN_DEC:
  - If mem_error=1: drop to byte mode (mem_extra=0, mem_addr=req_pc). Next state BYTE_WAIT.
  - Otherwise: latch the window and decode byte 0 at E2, then byte k at E(2+k).
- State BYTE_WAIT / BYTE_DEC (byte mode): each byte takes 2 cycles.
  - mem_error=1 in BYTE_DEC: err=1, done.
  - Otherwise decode the byte, increment mem_addr, and loop while the continuation bit is set.
- Accumulation: acc |= (b & 7F) << 7k. A byte with bit7=0 terminates decoding.
- Latency, window mode, n bytes: done is high in the cycle after E(1+n). For n=1, done follows E2.
- Byte limit N = req_wide?10:5. A byte N-1 with bit7=1 gives err=2, done, and next_pc = req_pc+N.
- Final-byte overflow check:
  - u32, byte 4: bits 6:4 must be 0.
  - s32, byte 4: bits 6:3 must all equal bit 3.
  - u64, byte 9: bits 6:1 must be 0.
  - s64, byte 9: bits 6:0 must all equal bit 0.
  - Violation gives err=3. value still reports the truncated acc.
- Sign extension: if signed, the last byte has bit6=1 and 7n < width, fill ones above bit 7n.
- 32-bit result: value[63:32] = signed ? value[31] : 0.
- On err != 0, value is undefined and the core must not consume it.
- done asserts with busy dropping to 0 in the same cycle. A req in that cycle is not accepted. A req while busy=1 is ignored.
- Address wrap: next_pc and mem_addr wrap modulo 2**(MEM_DEPTH+1).

Decomposition:
- Shared header leb128.vh holds the state encodings (IDLE, WIN_WAIT, WIN_DEC, BYTE_WAIT, BYTE_DEC), the err codes (LEB_OK, LEB_MEMERR, LEB_TOOLONG, LEB_OVERFLOW) and the limits 5/10. cpu.vh maps the err codes to trap values.
- One sub-module, leb128_acc: a per-byte accumulator with shift counter, overflow check and sign extension, shared by window mode and byte mode.

Test Plan:
- u32 at pc=17, ROM 0x03 -> value=3, next_pc=18, err=0, done one cycle after E2.
- u32 bytes E5 8E 26 -> value=624485 (0x98765), next_pc=pc+3, done after E4.
- s64 bytes C0 BB 78 -> value=0xFFFFFFFFFFFE1DC0 (-123456); s32 byte 7F -> 0xFFFFFFFFFFFFFFFF.
- u32 FF FF FF FF 0F -> 0xFFFFFFFF, err=0. FF FF FF FF 1F -> err=3. 80 80 80 80 80 -> err=2, next_pc=pc+5.
- 2-byte u32 (81 01) placed at rom_upper_bound-1 -> window mem_error, byte mode used, value=129. The same test with the second byte 0x81 -> err=1.
- Assert reset low during WIN_DEC of a 3-byte decode -> all outputs 0 immediately, no done pulse. After release, a new req decodes correctly.
